// File: rtl/pr_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pr_bus_arbiter_pkg
//  Purpose  : Shared defaults and FSM state encoding for the processor-bus
//             arbiter / device-window bridge.
//  Revision : 1.0  initial release
// ============================================================================
package pr_bus_arbiter_pkg;

    localparam int          c_dev_cnt     = 2;
    localparam int          c_dev_addr_wd = 4;
    localparam int          c_dev_id_wd   = 4;
    localparam logic [31:0] c_base        = 32'h0000_7F00;
    localparam int          c_timeout     = 16;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/pr_bus_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-requester round-robin picker. The pick is combinational;
//             the last-grant pointer is registered and advances only when
//             the caller accepts the grant.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic       o_gnt_valid,
    output logic       o_gnt_idx
);

    logic r_last;

    // Pick: a lone requester wins; on contention the one not granted last wins
    always_comb begin
        o_gnt_valid = |i_req;
        if (i_req == 2'b11) begin
            o_gnt_idx = ~r_last;
        end else begin
            o_gnt_idx = i_req[1];
        end
    end

    // Last-grant pointer; resets to 1 so master 0 wins the first contention
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= 1'b1;
        end else if (i_en && o_gnt_valid) begin
            r_last <= o_gnt_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pr_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pr_bus_arbiter
//  Purpose  : Registered arbiter/bridge from two processor-bus masters to the
//             memory-mapped device window: round-robin grant, device-ID
//             decode, wait-state handshake, timeout, error response.
//  Revision : 1.0  initial release
// ============================================================================
module pr_bus_arbiter
    import pr_bus_arbiter_pkg::*;
#(
    parameter int          DEV_CNT     = c_dev_cnt,
    parameter int          DEV_ADDR_WD = c_dev_addr_wd,
    parameter int          DEV_ID_WD   = c_dev_id_wd,
    parameter logic [31:0] BASE        = c_base,
    parameter int          TIMEOUT     = c_timeout
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              m_req,
    input  logic [1:0]              m_we,
    input  logic [63:0]             m_addr,
    input  logic [63:0]             m_wdata,
    output logic [1:0]              m_ack,
    output logic [1:0]              m_err,
    output logic [31:0]             m_rdata,
    output logic [DEV_CNT-1:0]      dev_sel,
    output logic [DEV_ADDR_WD-1:0]  dev_addr,
    output logic [31:0]             dev_wdata,
    output logic                    dev_we,
    input  logic [32*DEV_CNT-1:0]   dev_rdata,
    input  logic [DEV_CNT-1:0]      dev_ready
);

    localparam int c_id_lo = DEV_ADDR_WD;
    localparam int c_id_hi = DEV_ADDR_WD + DEV_ID_WD;
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);

    arb_state_t             r_state, w_state_n;
    logic                   r_gnt, w_gnt_n;
    logic [c_cnt_w-1:0]     r_cnt, w_cnt_n;
    logic [1:0]             r_m_ack, w_m_ack_n;
    logic [1:0]             r_m_err, w_m_err_n;
    logic [31:0]            r_m_rdata, w_m_rdata_n;
    logic [DEV_CNT-1:0]     r_dev_sel, w_dev_sel_n;
    logic [DEV_ADDR_WD-1:0] r_dev_addr, w_dev_addr_n;
    logic [31:0]            r_dev_wdata, w_dev_wdata_n;
    logic                   r_dev_we, w_dev_we_n;

    logic                   w_gnt_valid;
    logic                   w_gnt_idx;
    logic                   w_arb_en;
    logic [31:0]            w_addr;
    logic [31:0]            w_wdata;
    logic                   w_we;
    logic [DEV_ID_WD-1:0]   w_id;
    logic                   w_dec_ok;
    logic [DEV_CNT-1:0]     w_onehot;
    logic                   w_sel_ready;
    logic [31:0]            w_sel_rdata;

    assign w_arb_en = (r_state == ARB_IDLE);

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .rst         (rst),
        .i_req       (m_req),
        .i_en        (w_arb_en),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    // Granted master's request fields and the device-ID decode
    always_comb begin
        w_addr   = w_gnt_idx ? m_addr[63:32]  : m_addr[31:0];
        w_wdata  = w_gnt_idx ? m_wdata[63:32] : m_wdata[31:0];
        w_we     = m_we[w_gnt_idx];
        w_id     = w_addr[c_id_lo +: DEV_ID_WD];
        w_dec_ok = (w_addr >= BASE)
                && (32'(w_id) < 32'(DEV_CNT))
                && (w_addr[31:c_id_hi] == BASE[31:c_id_hi]);
        w_onehot = '0;
        for (int i = 0; i < DEV_CNT; i++) begin
            w_onehot[i] = (32'(w_id) == i);
        end
    end

    // Ready and read data of the selected device only; others are masked off
    always_comb begin
        w_sel_ready = |(r_dev_sel & dev_ready);
        w_sel_rdata = '0;
        for (int i = 0; i < DEV_CNT; i++) begin
            if (r_dev_sel[i]) begin
                w_sel_rdata = w_sel_rdata | dev_rdata[32*i +: 32];
            end
        end
    end

    // Next-state and next-output logic; ack/err/rdata default to 0 so they
    // only ever pulse for the single RESP cycle
    always_comb begin
        w_state_n     = r_state;
        w_gnt_n       = r_gnt;
        w_cnt_n       = r_cnt;
        w_m_ack_n     = '0;
        w_m_err_n     = '0;
        w_m_rdata_n   = '0;
        w_dev_sel_n   = r_dev_sel;
        w_dev_addr_n  = r_dev_addr;
        w_dev_wdata_n = r_dev_wdata;
        w_dev_we_n    = r_dev_we;

        case (r_state)
            ARB_IDLE: begin
                if (w_gnt_valid) begin
                    w_gnt_n = w_gnt_idx;
                    if (w_dec_ok) begin
                        w_state_n     = ARB_ACCESS;
                        w_cnt_n       = '0;
                        w_dev_sel_n   = w_onehot;
                        w_dev_addr_n  = w_addr[DEV_ADDR_WD-1:0];
                        w_dev_wdata_n = w_wdata;
                        w_dev_we_n    = w_we;
                    end else begin
                        w_state_n            = ARB_RESP;
                        w_m_ack_n[w_gnt_idx] = 1'b1;
                        w_m_err_n[w_gnt_idx] = 1'b1;
                    end
                end
            end
            ARB_ACCESS: begin
                if (w_sel_ready) begin
                    w_state_n        = ARB_RESP;
                    w_m_ack_n[r_gnt] = 1'b1;
                    w_m_rdata_n      = r_dev_we ? 32'h0 : w_sel_rdata;
                    w_dev_sel_n      = '0;
                    w_dev_we_n       = 1'b0;
                end else if (r_cnt == c_cnt_w'(TIMEOUT - 1)) begin
                    w_state_n        = ARB_RESP;
                    w_m_ack_n[r_gnt] = 1'b1;
                    w_m_err_n[r_gnt] = 1'b1;
                    w_dev_sel_n      = '0;
                    w_dev_we_n       = 1'b0;
                end else begin
                    w_cnt_n = r_cnt + c_cnt_w'(1);
                end
            end
            ARB_RESP: begin
                w_state_n = ARB_IDLE;
            end
            default: begin
                w_state_n   = ARB_IDLE;
                w_dev_sel_n = '0;
                w_dev_we_n  = 1'b0;
            end
        endcase
    end

    // State and all outputs registered; reset clears everything at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ARB_IDLE;
            r_gnt       <= 1'b0;
            r_cnt       <= '0;
            r_m_ack     <= '0;
            r_m_err     <= '0;
            r_m_rdata   <= '0;
            r_dev_sel   <= '0;
            r_dev_addr  <= '0;
            r_dev_wdata <= '0;
            r_dev_we    <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_gnt       <= w_gnt_n;
            r_cnt       <= w_cnt_n;
            r_m_ack     <= w_m_ack_n;
            r_m_err     <= w_m_err_n;
            r_m_rdata   <= w_m_rdata_n;
            r_dev_sel   <= w_dev_sel_n;
            r_dev_addr  <= w_dev_addr_n;
            r_dev_wdata <= w_dev_wdata_n;
            r_dev_we    <= w_dev_we_n;
        end
    end

    assign m_ack     = r_m_ack;
    assign m_err     = r_m_err;
    assign m_rdata   = r_m_rdata;
    assign dev_sel   = r_dev_sel;
    assign dev_addr  = r_dev_addr;
    assign dev_wdata = r_dev_wdata;
    assign dev_we    = r_dev_we;

endmodule
`default_nettype wire

// File: tb/tb_pr_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pr_bus_arbiter
//  Purpose  : Directed self-checking bench for pr_bus_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pr_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  m_req;
    logic [1:0]  m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [1:0]  m_ack;
    logic [1:0]  m_err;
    logic [31:0] m_rdata;
    logic [1:0]  dev_sel;
    logic [3:0]  dev_addr;
    logic [31:0] dev_wdata;
    logic        dev_we;
    logic [63:0] dev_rdata;
    logic [1:0]  dev_ready;

    int errors = 0;
    int checks = 0;

    pr_bus_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_ack     (m_ack),
        .m_err     (m_err),
        .m_rdata   (m_rdata),
        .dev_sel   (dev_sel),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_we    (dev_we),
        .dev_rdata (dev_rdata),
        .dev_ready (dev_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        m_req     = 2'b00;
        m_we      = 2'b00;
        m_addr    = '0;
        m_wdata   = '0;
        dev_rdata = '0;
        dev_ready = 2'b00;

        // Reset state
        cyc(); cyc();
        check("rst_ack",  64'(m_ack),   64'h0);
        check("rst_err",  64'(m_err),   64'h0);
        check("rst_rd",   64'(m_rdata), 64'h0);
        check("rst_sel",  64'(dev_sel), 64'h0);
        check("rst_we",   64'(dev_we),  64'h0);
        check("rst_addr", 64'(dev_addr),64'h0);
        rst = 1'b1;
        cyc();

        // 1: M0 read 0x7F04, zero wait states
        m_req = 2'b01; m_we = 2'b00;
        m_addr[31:0] = 32'h7F04;
        dev_rdata[31:0] = 32'hDEADBEEF;
        dev_ready = 2'b01;
        cyc();
        check("t1_sel",  64'(dev_sel),  64'h1);
        check("t1_addr", 64'(dev_addr), 64'h4);
        check("t1_ack0", 64'(m_ack),    64'h0);
        cyc();
        check("t1_ack",  64'(m_ack),   64'h1);
        check("t1_err",  64'(m_err),   64'h0);
        check("t1_rd",   64'(m_rdata), 64'hDEADBEEF);
        check("t1_sel0", 64'(dev_sel), 64'h0);
        m_req = 2'b00;
        cyc();
        check("t1_ackoff", 64'(m_ack),   64'h0);
        check("t1_rdoff",  64'(m_rdata), 64'h0);
        dev_ready = 2'b00;

        // 2: M1 write 0x7F13 = 0x55, ready after three wait cycles;
        //    dev 0 ready during the waits must be ignored
        m_req = 2'b10; m_we = 2'b10;
        m_addr[63:32]  = 32'h7F13;
        m_wdata[63:32] = 32'h55;
        dev_rdata[63:32] = 32'h12345678;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("t2_sel",   64'(dev_sel),   64'h2);
            check("t2_we",    64'(dev_we),    64'h1);
            check("t2_wdata", 64'(dev_wdata), 64'h55);
            check("t2_addr",  64'(dev_addr),  64'h3);
            check("t2_noack", 64'(m_ack),     64'h0);
            dev_ready = (k == 4) ? 2'b10 : 2'b01;
        end
        cyc();
        check("t2_ack", 64'(m_ack),   64'h2);
        check("t2_err", 64'(m_err),   64'h0);
        check("t2_rd",  64'(m_rdata), 64'h0);
        check("t2_we0", 64'(dev_we),  64'h0);
        m_req = 2'b00; m_we = 2'b00; dev_ready = 2'b00;
        cyc();

        // 3: both masters request continuously, zero-wait devices
        m_req = 2'b11; m_we = 2'b00;
        m_addr    = {32'h7F13, 32'h7F04};
        dev_rdata = {32'hBBBB_0001, 32'hAAAA_0000};
        dev_ready = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (k % 3 == 2) begin
                check("t3_ack", 64'(m_ack),
                      (((k - 2) / 3) % 2 == 0) ? 64'h1 : 64'h2);
                check("t3_rd",  64'(m_rdata),
                      (((k - 2) / 3) % 2 == 0) ? 64'hAAAA_0000 : 64'hBBBB_0001);
            end else if (k % 3 == 1) begin
                check("t3_sel", 64'(dev_sel),
                      (((k - 1) / 3) % 2 == 0) ? 64'h1 : 64'h2);
                check("t3_noack", 64'(m_ack), 64'h0);
            end else begin
                check("t3_idle", 64'(m_ack), 64'h0);
            end
        end
        m_req = 2'b00; dev_ready = 2'b00;
        cyc();

        // 4: invalid ID 3, then mismatched upper address bits
        m_req = 2'b01; m_addr[31:0] = 32'h7F30; dev_ready = 2'b11;
        cyc();
        check("t4_ack", 64'(m_ack),   64'h1);
        check("t4_err", 64'(m_err),   64'h1);
        check("t4_rd",  64'(m_rdata), 64'h0);
        check("t4_sel", 64'(dev_sel), 64'h0);
        m_req = 2'b00;
        cyc();
        check("t4_ackoff", 64'(m_ack), 64'h0);
        check("t4_erroff", 64'(m_err), 64'h0);
        cyc();
        m_req = 2'b01; m_addr[31:0] = 32'h0001_7F04;
        cyc();
        check("t4b_ack", 64'(m_ack),   64'h1);
        check("t4b_err", 64'(m_err),   64'h1);
        check("t4b_sel", 64'(dev_sel), 64'h0);
        m_req = 2'b00; dev_ready = 2'b00;
        cyc(); cyc();

        // 5: M0 read 0x7F00, never ready (dev 1 ready is not its device)
        m_req = 2'b01; m_addr[31:0] = 32'h7F00; dev_ready = 2'b10;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            check("t5_sel",   64'(dev_sel), 64'h1);
            check("t5_noack", 64'(m_ack),   64'h0);
        end
        cyc();
        check("t5_ack",  64'(m_ack),   64'h1);
        check("t5_err",  64'(m_err),   64'h1);
        check("t5_rd",   64'(m_rdata), 64'h0);
        check("t5_sel0", 64'(dev_sel), 64'h0);
        m_req = 2'b00; dev_ready = 2'b00;
        cyc();

        // 6: reset during a write ACCESS, then recovery
        m_req = 2'b10; m_we = 2'b10;
        m_addr[63:32] = 32'h7F10; m_wdata[63:32] = 32'hAA;
        cyc();
        check("t6_sel", 64'(dev_sel), 64'h2);
        check("t6_we",  64'(dev_we),  64'h1);
        #2 rst = 1'b0;
        #1;
        check("t6_async_sel", 64'(dev_sel), 64'h0);
        check("t6_async_we",  64'(dev_we),  64'h0);
        check("t6_async_ack", 64'(m_ack),   64'h0);
        m_req = 2'b00; m_we = 2'b00;
        cyc();
        rst = 1'b1;
        cyc();
        check("t6_noack", 64'(m_ack), 64'h0);
        m_req = 2'b10; m_addr[63:32] = 32'h7F13;
        dev_rdata[63:32] = 32'h0BAD_F00D; dev_ready = 2'b11;
        cyc();
        check("t6_m1_sel", 64'(dev_sel), 64'h2);
        cyc();
        check("t6_m1_ack", 64'(m_ack),   64'h2);
        check("t6_m1_rd",  64'(m_rdata), 64'h0BAD_F00D);
        m_req = 2'b00;
        cyc();
        m_req = 2'b11; m_addr = {32'h7F13, 32'h7F04};
        cyc();
        check("t6_cont_sel", 64'(dev_sel), 64'h1);
        cyc();
        check("t6_cont_ack", 64'(m_ack), 64'h1);
        m_req = 2'b00;
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
